ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the outbound side of the PS/2 link whose inbound side the keyboard decoder already handles.
- Sends one command byte per request to the keyboard, e.g. 0xED set-LEDs, 0xFF reset or 0xF4 enable.
- Runs the inhibit / request-to-send sequence, shifts the frame out on device-generated clocks and checks the device ACK bit.
- Drives the shared PS2_CLK/PS2_DATA open-drain lines through output-enables. The top level ties the pads low when the enables are 1 and leaves them high-Z otherwise.

Parameters:
INHIBIT_CYCLES, 10000, clk cycles PS2 clock is held low before the start bit (100 us at 100 MHz)
START_TIMEOUT_CYCLES, 1500000, max cycles from clock release to first device falling edge (15 ms)
XFER_TIMEOUT_CYCLES, 200000, max cycles from first falling edge to ACK sampled (2 ms)

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  asynchronous reset, active-low
tx_data  input  8  command byte
tx_valid  input  1  request; byte is accepted when tx_valid && tx_ready
tx_ready  output  1  high only in IDLE
ps2_clk_i  input  1  raw PS2_CLK pad level (asynchronous)
ps2_data_i  input  1  raw PS2_DATA pad level (asynchronous)
ps2_clk_oe  output  1  1 = pull PS2_CLK low
ps2_data_oe  output  1  1 = pull PS2_DATA low
busy  output  1  high in every state except IDLE; the decoder ignores frames while busy
done  output  1  one-cycle pulse when a transfer ends, whether it succeeds or fails
ack_ok  output  1  valid with done; 1 = device ACKed the byte
err_code  output  2  valid with done: 00 ok, 01 start timeout, 10 transfer timeout, 11 no ACK

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; ps2_clk_oe=ps2_data_oe=0 so both lines are released immediately, including mid-frame; tx_ready=1; busy=0; done=0; ack_ok=0; err_code=00; counters and shift register cleared.
- Input sync: ps2_clk_i and ps2_data_i each pass through 2 flip-flops.
- Falling edge: synced clock was 1 on the previous cycle and 0 on this cycle. Edge detection is enabled only in WAIT_CLK, SEND and ACK.
- Odd parity: parity bit = ~^data.
- IDLE: tx_ready=1. On accept, latch tx_data and the parity bit, then go to INHIBIT on the next cycle; tx_ready=0 from that cycle.
- INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to START.
- START: ps2_clk_oe=1, ps2_data_oe=1 for 1 cycle (start bit = 0), then go to WAIT_CLK.
- WAIT_CLK:
  - ps2_clk_oe=0, ps2_data_oe=1.
  - On the first falling edge, drive data bit 0 (ps2_data_oe = ~bit0), set bit index=1, clear the timeout counter and go to SEND.
  - If START_TIMEOUT_CYCLES elapse with no edge, end with err 01.
- SEND: on each falling edge, drive the next bit:
  - index 1..7: data bits 1..7, LSB first.
  - index 8: parity bit.
  - index 9: stop bit, ps2_data_oe=0.
  - After index 9, go to ACK.
- ACK:
  - ps2_data_oe=0.
  - On the next falling edge, sample synced data: 0 means ACK, go to WAIT_IDLE; 1 means end with err 11.
- Transfer timeout: counted across SEND and ACK. Reaching XFER_TIMEOUT_CYCLES ends with err 10.
- WAIT_IDLE: wait until synced clock and data are both 1, then end with ok.
- End (any path):
  - Release both lines.
  - done=1 for exactly 1 cycle, with ack_ok and err_code valid that cycle; err_code holds until the next done.
  - Return to IDLE; tx_ready=1 on the cycle after done.
- tx_valid outside IDLE is ignored and never queued. tx_data changes after accept have no effect.
- A device edge in the same cycle as a timeout expiry: the timeout wins.
- Counters saturate and never wrap.

Test Plan:
- INHIBIT_CYCLES=20, START_TIMEOUT_CYCLES=500, XFER_TIMEOUT_CYCLES=2000 in all scenarios.
- Send 0xED, device model clocks at 40-cycle period and ACKs → device reads start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; ps2_clk_oe high exactly 21 cycles after accept; done pulse with ack_ok=1, err_code=00.
- Send 0x01 then 0xFF back-to-back, holding tx_valid high → parity 0 then 1; the second byte is accepted only on the cycle after the first done; tx_valid during busy starts no extra frame.
- Device never clocks → done 500 cycles after clock release, err_code=01; both oe=0 afterwards.
- Device leaves data high on the 11th falling edge → done, ack_ok=0, err_code=11.
- Device stops clocking after 4 falling edges → done at 2000 cycles, err_code=10.
- rst asserted low mid-SEND (bit 5) → ps2_clk_oe and ps2_data_oe go low without waiting for a clk edge; after release, tx_ready=1 and a fresh 0xF4 transfer completes with ack_ok=1.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// Bundle of the command handshake, the raw PS/2 pad levels and the
// open-drain enables/status that connect the host transmitter to its user.
//
// Handshake: the user holds tx_valid high with tx_data stable; the byte is
// taken on the rising clk edge where tx_valid && tx_ready are both 1. tx_ready
// is high only while the transmitter is idle, so a request raised while a
// frame is in flight simply waits and is never queued. done pulses for one
// cycle per transfer; ack_ok/err_code are valid in that cycle and err_code
// holds until the next done.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic [1:0] err_code;
    logic [2:0] dbg_state;

    // user / pad side
    modport master (
        output tx_data, tx_valid, ps2_clk_i, ps2_data_i,
        input  tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok,
               err_code, dbg_state
    );

    // transmitter side
    modport slave (
        input  tx_data, tx_valid, ps2_clk_i, ps2_data_i,
        output tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok,
               err_code, dbg_state
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues request-to-send,
// shifts one command byte plus odd parity and stop out on device-generated
// clock falling edges, then checks the device ACK bit. Both PS/2 lines are
// driven only through active-high pull-low enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES       = 10000,
    parameter int START_TIMEOUT_CYCLES = 1500000,
    parameter int XFER_TIMEOUT_CYCLES  = 200000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave bus
);

    // One shared cycle counter serves the inhibit time and both timeouts, so
    // it is sized for the largest of them.
    localparam int MAX_A  = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ?
                            INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
    localparam int MAX_CY = (MAX_A > XFER_TIMEOUT_CYCLES) ? MAX_A : XFER_TIMEOUT_CYCLES;
    localparam int CW     = $clog2(MAX_CY + 1);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] ST_LAST  = CW'(START_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] XF_LAST  = CW'(XFER_TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_START  = 2'b01;
    localparam logic [1:0] ERR_XFER   = 2'b10;
    localparam logic [1:0] ERR_NO_ACK = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_START     = 3'd2,
        S_WAIT_CLK  = 3'd3,
        S_SEND      = 3'd4,
        S_ACK       = 3'd5,
        S_WAIT_IDLE = 3'd6,
        S_END       = 3'd7
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [8:0]      shreg_q, shreg_d;   // {parity, data}; ones shift in behind as stop
    logic            bit_q, bit_d;       // line level currently being driven in SEND
    logic [3:0]      idx_q, idx_d;       // index of the next bit to drive
    logic            ack_q, ack_d;
    logic [1:0]      err_q, err_d;

    logic            clk_s1_q, clk_s2_q, clk_prev_q;
    logic            data_s1_q, data_s2_q;
    logic            edge_en, fall;
    logic            clk_oe, data_oe, done;

    // Two-flop synchronisers for the pad levels plus the previous synced clock.
    // Reset to the idle-high level so no false falling edge appears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
        end else begin
            clk_s1_q   <= bus.ps2_clk_i;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            data_s1_q  <= bus.ps2_data_i;
            data_s2_q  <= data_s1_q;
        end
    end

    assign edge_en = (state_q == S_WAIT_CLK) || (state_q == S_SEND) || (state_q == S_ACK);
    assign fall    = edge_en && clk_prev_q && !clk_s2_q;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            bit_q   <= 1'b1;
            idx_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Next-state, datapath updates and line enables. Timeout checks come
    // before edge handling so an expiry wins over a simultaneous edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        ack_d   = ack_q;
        err_d   = err_q;
        clk_oe  = 1'b0;
        data_oe = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.tx_valid) begin
                    shreg_d = {~^bus.tx_data, bus.tx_data};
                    idx_d   = '0;
                    state_d = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                clk_oe = 1'b1;
                if (cnt_q >= INH_LAST) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end

            S_START: begin
                clk_oe  = 1'b1;
                data_oe = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT_CLK;
            end

            S_WAIT_CLK: begin
                data_oe = 1'b1;
                if (cnt_q >= ST_LAST) begin
                    ack_d   = 1'b0;
                    err_d   = ERR_START;
                    state_d = S_END;
                end else if (fall) begin
                    bit_d   = shreg_q[0];
                    shreg_d = {1'b1, shreg_q[8:1]};
                    idx_d   = 4'd1;
                    cnt_d   = '0;
                    state_d = S_SEND;
                end
            end

            S_SEND: begin
                data_oe = !bit_q;
                if (cnt_q >= XF_LAST) begin
                    ack_d   = 1'b0;
                    err_d   = ERR_XFER;
                    state_d = S_END;
                end else if (fall) begin
                    bit_d   = shreg_q[0];
                    shreg_d = {1'b1, shreg_q[8:1]};
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end
            end

            S_ACK: begin
                if (cnt_q >= XF_LAST) begin
                    ack_d   = 1'b0;
                    err_d   = ERR_XFER;
                    state_d = S_END;
                end else if (fall) begin
                    if (!data_s2_q) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        ack_d   = 1'b0;
                        err_d   = ERR_NO_ACK;
                        state_d = S_END;
                    end
                end
            end

            S_WAIT_IDLE: begin
                if (clk_s2_q && data_s2_q) begin
                    ack_d   = 1'b1;
                    err_d   = ERR_OK;
                    state_d = S_END;
                end
            end

            S_END: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ps2_clk_oe  = clk_oe;
    assign bus.ps2_data_oe = data_oe;
    assign bus.done        = done;
    assign bus.tx_ready    = (state_q == S_IDLE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.ack_ok      = ack_q;
    assign bus.err_code    = err_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for the PS/2 host transmitter: a pad/device model generates clocks,
// reads the frame and optionally ACKs; results are checked against a frame
// model built from the odd-parity/LSB-first framing rules.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int ST  = 500;
    localparam int XT  = 2000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ps2_host_tx_if if_i();

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    // Open-drain pads: low when either side pulls.
    assign if_i.ps2_clk_i  = ~(if_i.ps2_clk_oe | dev_clk_low);
    assign if_i.ps2_data_i = ~(if_i.ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT_CYCLES(ST),
        .XFER_TIMEOUT_CYCLES(XT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(if_i)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errs   = 0;
    logic [10:0] exp_q[$];

    int   cyc = 0;
    int   acc_count = 0, acc_cyc = 0;
    int   done_count = 0, done_cyc = 0, dbl_done = 0;
    logic done_ack = 1'b0, done_oe = 1'b0, prev_done = 1'b0;
    logic [1:0] done_err = 2'b00;

    // Event monitor: records accepts and done pulses on pre-edge values.
    always @(posedge clk) begin
        if (if_i.tx_valid && if_i.tx_ready && rst) begin
            acc_count <= acc_count + 1;
            acc_cyc   <= cyc;
        end
        if (if_i.done) begin
            done_count <= done_count + 1;
            done_cyc   <= cyc;
            done_ack   <= if_i.ack_ok;
            done_err   <= if_i.err_code;
            done_oe    <= if_i.ps2_clk_oe | if_i.ps2_data_oe;
            if (prev_done) dbl_done <= dbl_done + 1;
        end
        prev_done <= if_i.done;
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        f[0]   = 1'b0;
        f[8:1] = d;
        f[9]   = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        f[10]  = 1'b1;
        return f;
    endfunction

    // ---------------- driver tasks ----------------
    // Raise a request at a negedge and return at the negedge after acceptance.
    task automatic request(input logic [7:0] data, input bit hold, input logic [7:0] data_after);
        int guard = 0;
        if_i.tx_data  = data;
        if_i.tx_valid = 1'b1;
        while (!if_i.tx_ready && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", {31'd0, if_i.tx_ready}, 32'd1);
        @(negedge clk);
        if (hold) begin
            if_i.tx_data = data_after;
        end else begin
            if_i.tx_valid = 1'b0;
            if_i.tx_data  = 8'($urandom);
        end
    endtask

    // Device: read the start bit, then generate falling edges, read each bit
    // on the rising edge and optionally pull data low for the ACK edge.
    task automatic device_clock(input int half, input int n_edges, input bit do_ack,
                                output logic [10:0] bits, output int fall_cyc);
        bits     = '1;
        fall_cyc = cyc;
        bits[0]  = if_i.ps2_data_i;
        repeat (5) @(negedge clk);
        for (int e = 1; e <= n_edges; e++) begin
            if (e == 1) fall_cyc = cyc;
            dev_clk_low = 1'b1;
            repeat (half) @(negedge clk);
            dev_clk_low = 1'b0;
            if (e <= 10) bits[e] = if_i.ps2_data_i;
            if (e == 10 && do_ack) dev_data_low = 1'b1;
            repeat (half) @(negedge clk);
            if (e == 11) dev_data_low = 1'b0;
        end
        dev_data_low = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] data, input int half, input int n_edges,
                             input bit do_ack, input bit hold, input logic [7:0] data_after,
                             output logic [10:0] bits, output int inh_len, output int rel_cyc,
                             output int fall_cyc);
        int start_done = done_count;
        int guard = 0;
        request(data, hold, data_after);
        inh_len = 0;
        while (if_i.ps2_clk_oe && inh_len < 200) begin
            inh_len++;
            @(negedge clk);
        end
        rel_cyc = cyc;
        device_clock(half, n_edges, do_ack, bits, fall_cyc);
        while (done_count == start_done && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", {31'd0, done_count != start_done}, 32'd1);
    endtask

    // Compare received bits 0..last against the next expected frame.
    task automatic check_bits(input string tag, input logic [10:0] bits, input int last);
        logic [10:0] exp_f = exp_q.pop_front();
        for (int k = 0; k <= last && k <= 10; k++)
            check($sformatf("%s_bit%0d", tag, k), {31'd0, bits[k]}, {31'd0, exp_f[k]});
    endtask

    typedef struct {
        logic [7:0] data;
        int         n_edges;
        bit         do_ack;
        bit         exp_ack;
        logic [1:0] exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [10:0] bits;
        int inh, rel, fall, d1, acc0;

        vecs[0] = '{data: 8'hED, n_edges: 11, do_ack: 1'b1, exp_ack: 1'b1, exp_err: 2'b00};
        vecs[1] = '{data: 8'hF4, n_edges: 0,  do_ack: 1'b0, exp_ack: 1'b0, exp_err: 2'b01};
        vecs[2] = '{data: 8'h55, n_edges: 11, do_ack: 1'b0, exp_ack: 1'b0, exp_err: 2'b11};
        vecs[3] = '{data: 8'hA3, n_edges: 4,  do_ack: 1'b0, exp_ack: 1'b0, exp_err: 2'b10};
        vecs[4] = '{data: 8'hFF, n_edges: 11, do_ack: 1'b1, exp_ack: 1'b1, exp_err: 2'b00};

        if_i.tx_data  = 8'h00;
        if_i.tx_valid = 1'b0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, if_i.tx_ready}, 32'd1);
        check("rst_busy",  {31'd0, if_i.busy}, 32'd0);
        check("rst_done",  {31'd0, if_i.done}, 32'd0);
        check("rst_oe",    {30'd0, if_i.ps2_clk_oe, if_i.ps2_data_oe}, 32'd0);
        check("rst_err",   {30'd0, if_i.err_code}, 32'd0);
        check("rst_ack",   {31'd0, if_i.ack_ok}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // table-driven frames
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(model_frame(vecs[i].data));
            run_frame(vecs[i].data, 20, vecs[i].n_edges, vecs[i].do_ack, 1'b0, 8'h00,
                      bits, inh, rel, fall);
            check($sformatf("v%0d_inhibit_len", i), inh, INH + 1);
            check($sformatf("v%0d_ack", i), {31'd0, done_ack}, {31'd0, vecs[i].exp_ack});
            check($sformatf("v%0d_err", i), {30'd0, done_err}, {30'd0, vecs[i].exp_err});
            check($sformatf("v%0d_oe_at_done", i), {31'd0, done_oe}, 32'd0);
            check_bits($sformatf("v%0d", i), bits, vecs[i].n_edges);
            if (vecs[i].exp_err == 2'b01)
                check($sformatf("v%0d_start_tmo", i), done_cyc - rel, ST);
            if (vecs[i].exp_err == 2'b10)
                check($sformatf("v%0d_xfer_tmo_win", i),
                      {31'd0, (done_cyc - fall >= XT) && (done_cyc - fall <= XT + 10)}, 32'd1);
            repeat (5) @(negedge clk);
            check($sformatf("v%0d_err_hold", i), {30'd0, if_i.err_code}, {30'd0, vecs[i].exp_err});
            check($sformatf("v%0d_idle_oe", i), {30'd0, if_i.ps2_clk_oe, if_i.ps2_data_oe}, 32'd0);
            check($sformatf("v%0d_idle_ready", i), {31'd0, if_i.tx_ready}, 32'd1);
        end

        // back-to-back with tx_valid held; tx_data changes after accept
        acc0 = acc_count;
        exp_q.push_back(model_frame(8'h01));
        run_frame(8'h01, 20, 11, 1'b1, 1'b1, 8'hFF, bits, inh, rel, fall);
        check_bits("b2b0", bits, 10);
        check("b2b0_ack", {31'd0, done_ack}, 32'd1);
        check("b2b0_single_accept", acc_count - acc0, 1);
        d1 = done_cyc;
        exp_q.push_back(model_frame(8'hFF));
        run_frame(8'hFF, 20, 11, 1'b1, 1'b0, 8'h00, bits, inh, rel, fall);
        check_bits("b2b1", bits, 10);
        check("b2b1_accept_cycle", acc_cyc, d1 + 1);
        check("b2b1_ack", {31'd0, done_ack}, 32'd1);
        check("b2b_total_accepts", acc_count - acc0, 2);

        // randomized bytes and device clock rates
        for (int r = 0; r < 6; r++) begin
            logic [7:0] d = 8'($urandom_range(0, 255));
            int half = $urandom_range(10, 25);
            exp_q.push_back(model_frame(d));
            run_frame(d, half, 11, 1'b1, 1'b0, 8'h00, bits, inh, rel, fall);
            check_bits($sformatf("rnd%0d", r), bits, 10);
            check($sformatf("rnd%0d_ack", r), {31'd0, done_ack}, 32'd1);
            check($sformatf("rnd%0d_err", r), {30'd0, done_err}, 32'd0);
            repeat (3) @(negedge clk);
        end

        // reset during inhibit releases the clock line without a clk edge
        request(8'h12, 1'b0, 8'h00);
        repeat (5) @(negedge clk);
        check("inh_clk_oe_before_rst", {31'd0, if_i.ps2_clk_oe}, 32'd1);
        #2 rst = 1'b0;
        #1 check("inh_rst_clk_oe", {31'd0, if_i.ps2_clk_oe}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // reset mid-SEND while bit 5 is on the line
        request(8'hF4, 1'b0, 8'h00);
        begin
            int guard = 0;
            while (if_i.ps2_clk_oe && guard < 200) begin
                @(negedge clk);
                guard++;
            end
        end
        device_clock(20, 6, 1'b0, bits, fall);
        check("send_busy_before_rst", {31'd0, if_i.busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("send_rst_oe", {30'd0, if_i.ps2_clk_oe, if_i.ps2_data_oe}, 32'd0);
        check("send_rst_busy", {31'd0, if_i.busy}, 32'd0);
        check("send_rst_ready", {31'd0, if_i.tx_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, if_i.tx_ready}, 32'd1);
        exp_q.push_back(model_frame(8'hF4));
        run_frame(8'hF4, 20, 11, 1'b1, 1'b0, 8'h00, bits, inh, rel, fall);
        check_bits("post_rst", bits, 10);
        check("post_rst_ack", {31'd0, done_ack}, 32'd1);
        check("post_rst_err", {30'd0, done_err}, 32'd0);

        repeat (3) @(negedge clk);
        check("done_single_cycle", dbl_done, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
